// File: rtl/gcd_pkg.sv
// gcd_pkg: scheduler state encoding and default operand width shared by the GCD slice.
package gcd_pkg;
    localparam int BIT_LEN_DEF = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } sched_state_t;
endpackage

// File: rtl/gcd_scheduler_if.sv
// gcd_scheduler_if: requester-side bus of the GCD scheduler (requests, operands, accept/response).
interface gcd_scheduler_if #(
    parameter int BIT_LEN = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*BIT_LEN-1:0] num_0;
    logic [NUM_REQ*BIT_LEN-1:0] num_1;
    logic [NUM_REQ-1:0]         ack;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [BIT_LEN-1:0]         rsp_gcd;
    logic                       busy;
    modport master (output req, num_0, num_1, input ack, rsp_valid, rsp_gcd, busy);
    modport slave  (input req, num_0, num_1, output ack, rsp_valid, rsp_gcd, busy);
endinterface

// File: rtl/gcd_processor.sv
// gcd_processor: subtractive Euclid datapath; done pulses while busy once an operand is zero or both match.
module gcd_processor import gcd_pkg::*; #(
    parameter int BIT_LEN = BIT_LEN_DEF
) (
    input  logic               clk_i,
    input  logic               reset_n,
    input  logic               start,
    input  logic [BIT_LEN-1:0] num_0,
    input  logic [BIT_LEN-1:0] num_1,
    output logic               busy,
    output logic               done,
    output logic [BIT_LEN-1:0] gcd_op
);
    logic [BIT_LEN-1:0] a, b;
    logic               fin;
    assign fin    = (a == '0) || (b == '0) || (a == b);
    assign done   = busy && fin;
    assign gcd_op = (a == '0) ? b : a;
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
            a    <= '0;
            b    <= '0;
        end else if (start) begin
            busy <= 1'b1;
            a    <= num_0;
            b    <= num_1;
        end else if (busy) begin
            if (fin) busy <= 1'b0;
            else if (a > b) a <= a - b;
            else b <= b - a;
        end
    end
endmodule

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: combinational round-robin pick of the first set request at or above rr_ptr.
module gcd_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any_req,
    output logic [IW-1:0]      grant
);
    logic [IW-1:0] idx;
    assign any_req = |req;
    // Scan offsets from far to near so the nearest set bit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) grant = idx;
        end
    end
endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin sharing of one GCD datapath between NUM_REQ level-request clients.
module gcd_scheduler import gcd_pkg::*; #(
    parameter int BIT_LEN = BIT_LEN_DEF,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*BIT_LEN-1:0] num_0_i,
    input  logic [NUM_REQ*BIT_LEN-1:0] num_1_i,
    output logic [NUM_REQ-1:0]         ack_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    output logic [BIT_LEN-1:0]         rsp_gcd_o,
    output logic                       busy_o
);
    localparam int IW = $clog2(NUM_REQ);
    sched_state_t       state, state_nx;
    logic [IW-1:0]      rr_ptr, grant, grant_idx;
    logic               any_req, dp_start, dp_busy, dp_done;
    logic [BIT_LEN-1:0] op_0, op_1, result_reg, dp_gcd;
    gcd_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req     (req_i),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .grant   (grant)
    );
    gcd_processor #(.BIT_LEN(BIT_LEN)) u_dp (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .start   (dp_start),
        .num_0   (op_0),
        .num_1   (op_1),
        .busy    (dp_busy),
        .done    (dp_done),
        .gcd_op  (dp_gcd)
    );
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            grant_idx  <= '0;
            op_0       <= '0;
            op_1       <= '0;
            result_reg <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                op_0      <= num_0_i[int'(grant)*BIT_LEN +: BIT_LEN];
                op_1      <= num_1_i[int'(grant)*BIT_LEN +: BIT_LEN];
                grant_idx <= grant;
                rr_ptr    <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            if (state == WAIT && dp_done) result_reg <= dp_gcd;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_req ? LAUNCH : IDLE;
            LAUNCH:  state_nx = WAIT;
            WAIT:    state_nx = dp_done ? RESPOND : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    // ack is combinational on req, so it is gated by reset to stay quiet while reset is held.
    always_comb begin
        ack_o       = (reset_n && state == IDLE && any_req) ? NUM_REQ'(1) << grant : '0;
        rsp_valid_o = (state == RESPOND) ? NUM_REQ'(1) << grant_idx : '0;
        dp_start    = state == LAUNCH;
        busy_o      = state != IDLE || dp_busy;
        rsp_gcd_o   = result_reg;
    end
endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: directed vector table plus contention, fairness and mid-operation reset sequences.
module tb_gcd_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        int         lat;
    } vec_t;

    gcd_scheduler_if #(.BIT_LEN(8), .NUM_REQ(4)) bus();

    gcd_scheduler #(.BIT_LEN(8), .NUM_REQ(4)) dut (
        .clk_i       (clk),
        .reset_n     (reset_n),
        .req_i       (bus.req),
        .num_0_i     (bus.num_0),
        .num_1_i     (bus.num_1),
        .ack_o       (bus.ack),
        .rsp_valid_o (bus.rsp_valid),
        .rsp_gcd_o   (bus.rsp_gcd),
        .busy_o      (bus.busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        oh2i = -1;
        for (int i = 0; i < 4; i++) if (v[i]) oh2i = i;
    endfunction

    task automatic drive(input int idx, input logic [7:0] a, input logic [7:0] b, input logic v);
        bus.num_0[idx*8 +: 8] = a;
        bus.num_1[idx*8 +: 8] = b;
        bus.req[idx] = v;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack"}, {28'd0, bus.ack}, 0);
        check({tag, "_rsp_valid"}, {28'd0, bus.rsp_valid}, 0);
        check({tag, "_rsp_gcd"}, {24'd0, bus.rsp_gcd}, 0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Single request: wait for ack, drop req, then time the response from the ack cycle.
    task automatic serve(input int idx, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [7:0] g, output bit ok);
        int  n;
        bit  all_busy;
        ok = 0;
        lat = 0;
        g = 0;
        n = 0;
        all_busy = 1;
        @(posedge clk);
        #1 drive(idx, a, b, 1'b1);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ack[idx] && n < 20);
        check("ack_onehot", {28'd0, bus.ack}, 32'(4'b0001 << idx));
        @(posedge clk);
        #1 bus.req[idx] = 1'b0;
        if (n >= 20 && !bus.ack[idx]) return;
        do begin
            @(negedge clk);
            lat++;
            all_busy &= bus.busy;
        end while (!bus.rsp_valid[idx] && lat < 600);
        check("rsp_valid_onehot", {28'd0, bus.rsp_valid}, 32'(4'b0001 << idx));
        check("busy_during_op", {31'd0, all_busy}, 1);
        ok = bus.rsp_valid[idx];
        g = bus.rsp_gcd;
    endtask

    always @(negedge clk) begin
        if (reset_n && (|bus.ack || |bus.rsp_valid)) begin
            check("ack_at_most_one", {31'd0, $onehot0(bus.ack)}, 1);
            check("rsp_at_most_one", {31'd0, $onehot0(bus.rsp_valid)}, 1);
            check("ack_rsp_exclusive", {31'd0, (|bus.ack) && (|bus.rsp_valid)}, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[10];
        int         lat;
        logic [7:0] g;
        bit         ok;
        int         acks[$];
        int         rsp_i[$];
        logic [7:0] rsp_g[$];
        int         cyc;
        logic [3:0] a_seen;
        bit         bad;
        bit         seen2;
        int         exp_ack[4];
        int         exp_g[4];

        vecs = '{
            '{0, 8'd48,  8'd18,  8'd6,   0},
            '{1, 8'd0,   8'd35,  8'd35,  3},
            '{2, 8'd35,  8'd0,   8'd35,  3},
            '{3, 8'd0,   8'd0,   8'd0,   3},
            '{0, 8'd255, 8'd255, 8'd255, 0},
            '{1, 8'd255, 8'd1,   8'd1,   0},
            '{2, 8'd100, 8'd75,  8'd25,  0},
            '{3, 8'd17,  8'd13,  8'd1,   0},
            '{0, 8'd128, 8'd96,  8'd32,  0},
            '{1, 8'd200, 8'd150, 8'd50,  0}
        };
        bus.req = 4'b1010;
        bus.num_0 = '0;
        bus.num_1 = '0;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("in_reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        bus.req = '0;

        foreach (vecs[i]) begin
            serve(vecs[i].idx, vecs[i].a, vecs[i].b, lat, g, ok);
            check($sformatf("vec%0d_rsp_seen", i), {31'd0, ok}, 1);
            check($sformatf("vec%0d_gcd", i), {24'd0, g}, {24'd0, vecs[i].g});
            if (vecs[i].lat != 0) check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end
        repeat (5) @(negedge clk);
        check("rsp_gcd_hold", {24'd0, bus.rsp_gcd}, 50);
        check("idle_not_busy", {31'd0, bus.busy}, 0);

        // Contention: all four at once, each drops its request after its ack.
        apply_reset();
        drive(0, 8'd12, 8'd8, 1'b1);
        drive(1, 8'd9, 8'd6, 1'b1);
        drive(2, 8'd7, 8'd5, 1'b1);
        drive(3, 8'd64, 8'd16, 1'b1);
        exp_ack = '{0, 1, 2, 3};
        exp_g = '{4, 3, 1, 16};
        cyc = 0;
        while (rsp_i.size() < 4 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            a_seen = bus.ack;
            if (|a_seen) acks.push_back(oh2i(a_seen));
            if (|bus.rsp_valid) begin
                rsp_i.push_back(oh2i(bus.rsp_valid));
                rsp_g.push_back(bus.rsp_gcd);
            end
            @(posedge clk);
            #1 bus.req = bus.req & ~a_seen;
        end
        check("contention_ack_count", acks.size(), 4);
        check("contention_rsp_count", rsp_i.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("contention_ack%0d", i), acks.size() > i ? acks[i] : -1, exp_ack[i]);
            check($sformatf("contention_rsp_idx%0d", i), rsp_i.size() > i ? rsp_i[i] : -1, exp_ack[i]);
            check($sformatf("contention_gcd%0d", i), rsp_g.size() > i ? {24'd0, rsp_g[i]} : 32'hffff_ffff, exp_g[i]);
        end

        // Fairness: requesters 0 and 2 hold their requests continuously.
        apply_reset();
        acks.delete();
        drive(0, 8'd10, 8'd4, 1'b1);
        drive(2, 8'd9, 8'd3, 1'b1);
        bad = 0;
        cyc = 0;
        while (acks.size() < 4 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (|bus.ack) acks.push_back(oh2i(bus.ack));
            bad |= bus.ack[1] | bus.ack[3];
        end
        @(posedge clk);
        #1 bus.req = '0;
        exp_ack = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++)
            check($sformatf("fair_ack%0d", i), acks.size() > i ? acks[i] : -1, exp_ack[i]);
        check("fair_no_ack_1_3", {31'd0, bad}, 0);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("fair_drains", {31'd0, bus.busy}, 0);

        // Reset in WAIT aborts the long (255,1) job.
        @(posedge clk);
        #1 drive(2, 8'd255, 8'd1, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.ack[2] && cyc < 20);
        check("abort_ack2", {31'd0, bus.ack[2]}, 1);
        @(posedge clk);
        #1 bus.req[2] = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_busy_in_wait", {31'd0, bus.busy}, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_quiet("abort_reset");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen2 = 0;
        repeat (300) begin
            @(negedge clk);
            seen2 |= bus.rsp_valid[2];
        end
        check("abort_no_rsp2", {31'd0, seen2}, 0);
        check("abort_idle", {31'd0, bus.busy}, 0);
        serve(3, 8'd0, 8'd0, lat, g, ok);
        check("post_abort_rsp3", {31'd0, ok}, 1);
        check("post_abort_gcd", {24'd0, g}, 0);
        check("post_abort_latency", lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gcd_scheduler.md
GCD_SCHEDULER -- requirements
Module: gcd_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- BIT_LEN, 8, operand and result width.
- NUM_REQ, 4, number of requesters, minimum 2.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i  input  1  the single clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_i  input  NUM_REQ  per-requester request, level.
- num_0_i  input  NUM_REQ*BIT_LEN  operand 0; requester i occupies bits [i*BIT_LEN +: BIT_LEN].
- num_1_i  input  NUM_REQ*BIT_LEN  operand 1; same packing as num_0_i.
- ack_o  output  NUM_REQ  one-cycle accept pulse per requester.
- rsp_valid_o  output  NUM_REQ  one-cycle result-valid pulse per requester.
- rsp_gcd_o  output  BIT_LEN  result, shared by all requesters.
- busy_o  output  1  scheduler not in IDLE.

REQ-003 The block SHALL use one clock, clk_i; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL share one GCD datapath instance between NUM_REQ requesters.
REQ-005 Handshake:
- A requester SHALL hold req_i[i] high with stable operands until it sees ack_o[i].
- Operands SHALL be latched in the ack cycle.
- Dropping req_i[i] before ack SHALL withdraw the request silently.
REQ-006 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESPOND, with encodings from the shared package.
REQ-007 IDLE:
- If any req_i bit is high, the block SHALL grant the first set bit searching upward from rr_ptr with wrap-around.
- It SHALL assert ack_o[grant] for that cycle, latch both operands and the grant index, set rr_ptr to (grant+1) mod NUM_REQ, and go to LAUNCH.
- Otherwise it SHALL stay in IDLE.
REQ-008 LAUNCH: the block SHALL drive the datapath start for exactly one cycle with the latched operands, then go to WAIT.
REQ-009 WAIT: on the datapath done pulse, the block SHALL capture the datapath result into result_reg and go to RESPOND. There SHALL be no timeout.
REQ-010 RESPOND: the block SHALL assert rsp_valid_o[grant] for exactly one cycle, drive rsp_gcd_o from result_reg, and go to IDLE.
REQ-011 rsp_gcd_o SHALL hold the last result between responses.
REQ-012 At most one ack_o bit and at most one rsp_valid_o bit SHALL be high in any cycle.
REQ-013 ack_o and rsp_valid_o SHALL never both be high in the same cycle.
REQ-014 req_i SHALL be sampled only in IDLE; requests raised in any other state wait.
- A requester still holding req after its own response SHALL be treated as a new request.
REQ-015 busy_o SHALL be high in LAUNCH, WAIT and RESPOND.
REQ-016 Latency from ack_o to rsp_valid_o SHALL be (datapath start-to-done cycles) + 2.
- When either operand is zero this SHALL be exactly 3 cycles.
REQ-017 Results SHALL follow the datapath rules unchanged:
- gcd(0,0) = 0.
- gcd(0,x) = x.
- Width is BIT_LEN with no truncation.

Reset
REQ-018 On reset_n low, the block SHALL go to IDLE and clear rr_ptr, the latched operands, the grant index and result_reg to 0.
REQ-019 During reset, ack_o, rsp_valid_o, rsp_gcd_o and busy_o SHALL all be 0.
REQ-020 A reset during LAUNCH, WAIT or RESPOND SHALL abort the in-flight operation.
- No rsp_valid_o SHALL be produced for the aborted operation.
- The datapath instance SHALL receive the same reset_n.
REQ-021 The first grant after reset SHALL begin its search at requester 0.

Structure
REQ-022 Shared package gcd_pkg SHALL hold the scheduler state encoding and the default BIT_LEN.
REQ-023 The block SHALL instantiate gcd_processor (start, busy, gcd_op, done) once as its datapath.
REQ-024 Round-robin selection SHALL be a sub-module, gcd_rr_arbiter.
- Inputs: req vector and rr_ptr.
- Outputs: any-request flag and grant index.
- It SHALL be purely combinational.
REQ-025 The target size SHALL be 120–400 lines of RTL total.

Verification (BIT_LEN=8, NUM_REQ=4)
REQ-026 Single request: req_i[0] with (48,18) → one ack_o[0] pulse, busy_o high until done, then rsp_valid_o[0] with rsp_gcd_o=6.
REQ-027 Zero operand: req_i[1] with (0,35) → rsp_valid_o[1] with rsp_gcd_o=35, exactly 3 cycles after ack_o[1].
REQ-028 Contention: after reset, all four requests raised together with (12,8), (9,6), (7,5), (64,16) → acks in order 0,1,2,3, results 4, 3, 1, 16 on the matching rsp_valid_o bits.
REQ-029 Fairness: req_i[0] and req_i[2] held high continuously → grants alternate 0,2,0,2; requesters 1 and 3 never acked.
REQ-030 Reset mid-operation: req_i[2] with (255,1), reset_n pulsed low during WAIT → all outputs 0, no rsp_valid_o[2]. A subsequent req_i[3] with (0,0) SHALL give rsp_gcd_o=0 on rsp_valid_o[3].
